// File: rtl/dcache_direct_if.sv
// CPU load/store and block-memory signal bundle for dcache_direct.
// The cache binds to the slave modport; the CPU/memory environment uses master.
interface dcache_direct_if #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 16
);
  logic [WORD_SIZE-1:0]            cpu_ptr;
  logic [WORD_SIZE-1:0]            cpu_wdata;
  logic                            cpu_read;
  logic                            cpu_write;
  logic [WORD_SIZE-1:0]            cpu_rdata;
  logic                            cpu_stall;
  logic [WORD_SIZE-1:0]            mem_ptr;
  logic [BLOCK_SIZE*WORD_SIZE-1:0] mem_wblock;
  logic [BLOCK_SIZE*WORD_SIZE-1:0] mem_rblock;
  logic                            mem_write_enable;

  modport slave (
    input  cpu_ptr, cpu_wdata, cpu_read, cpu_write, mem_rblock,
    output cpu_rdata, cpu_stall, mem_ptr, mem_wblock, mem_write_enable
  );

  modport master (
    output cpu_ptr, cpu_wdata, cpu_read, cpu_write, mem_rblock,
    input  cpu_rdata, cpu_stall, mem_ptr, mem_wblock, mem_write_enable
  );
endinterface

// File: rtl/dcache_direct.sv
// Direct-mapped write-back/write-allocate data cache with whole-block refill.
// Define DCACHE_STATS_EN to add hit_count/miss_count outputs.
module dcache_direct #(
  parameter int WORD_SIZE   = 32,
  parameter int BLOCK_SIZE  = 16,
  parameter int NUM_LINES   = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  dcache_direct_if.slave    bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);
  localparam int OFF_W  = $clog2(BLOCK_SIZE);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
  localparam int LINE_W = BLOCK_SIZE * WORD_SIZE;
  localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_REFILL    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    line_q [NUM_LINES];

  logic [IDX_W-1:0]     idx;
  logic [OFF_W-1:0]     off;
  logic [TAG_W-1:0]     ptag;
  logic [TAG_W-1:0]     cur_tag;
  logic [LINE_W-1:0]    cur_line;
  logic [LINE_W-1:0]    wr_line;
  logic [WORD_SIZE-1:0] line_words [BLOCK_SIZE];
  logic                 req, hit;
  logic                 stall_c, we_c, refill_done, wr_hit;
  logic [WORD_SIZE-1:0] rdata_c, mptr_c;

  assign idx      = bus.cpu_ptr[OFF_W +: IDX_W];
  assign off      = bus.cpu_ptr[OFF_W-1:0];
  assign ptag     = bus.cpu_ptr[WORD_SIZE-1 -: TAG_W];
  assign cur_tag  = tag_q[idx];
  assign cur_line = line_q[idx];
  assign req      = bus.cpu_read | bus.cpu_write;
  assign hit      = valid_q[idx] && (cur_tag == ptag);

  // Word 0 sits in the MSBs of a block; the merged line replaces only the addressed word.
  for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_words
    assign line_words[gi] = cur_line[(BLOCK_SIZE-1-gi)*WORD_SIZE +: WORD_SIZE];
    assign wr_line[(BLOCK_SIZE-1-gi)*WORD_SIZE +: WORD_SIZE] =
        (off == OFF_W'(gi)) ? bus.cpu_wdata : line_words[gi];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_c     = 1'b0;
    we_c        = 1'b0;
    refill_done = 1'b0;
    wr_hit      = 1'b0;
    rdata_c     = '0;
    mptr_c      = {bus.cpu_ptr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            rdata_c = bus.cpu_read ? line_words[off] : '0;
            wr_hit  = bus.cpu_write;
          end else begin
            stall_c = 1'b1;
            state_d = (valid_q[idx] && dirty_q[idx]) ? S_WRITEBACK : S_REFILL;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WRITEBACK: begin
        stall_c = 1'b1;
        mptr_c  = {cur_tag, idx, {OFF_W{1'b0}}};
        if (cnt_q == '0) begin
          we_c    = 1'b1;
          state_d = S_REFILL;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_REFILL: begin
        stall_c = 1'b1;
        mptr_c  = {ptag, idx, {OFF_W{1'b0}}};
        if (cnt_q == '0) begin
          refill_done = 1'b1;
          state_d     = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stall is forced low while reset is held so a waiting CPU sees the reset value.
  assign bus.cpu_stall        = rst_n & stall_c;
  assign bus.cpu_rdata        = rdata_c;
  assign bus.mem_ptr          = mptr_c;
  assign bus.mem_wblock       = cur_line;
  assign bus.mem_write_enable = we_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (refill_done) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (wr_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (refill_done) begin
      tag_q[idx]  <= ptag;
      line_q[idx] <= bus.mem_rblock;
    end else if (wr_hit) begin
      line_q[idx] <= wr_line;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        post_refill_q;
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_refill_q <= 1'b0;
      hit_q         <= '0;
      miss_q        <= '0;
    end else begin
      post_refill_q <= refill_done;
      if (state_q == S_IDLE && req && hit && !post_refill_q)
        hit_q <= hit_q + 32'd1;
      if (state_q == S_IDLE && req && !hit)
        miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif
endmodule

// File: tb/tb_dcache_direct.sv
// Directed bench for dcache_direct: word-array memory model behind the block port
// and a queue of expected load data popped when each request completes.
module tb_dcache_direct;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_init = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   we_count = 0;
  logic [31:0] we_addr = '0;
  logic [31:0] last_mptr = '0;
  logic [31:0] mem [256];
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  dcache_direct_if #(.WORD_SIZE(32), .BLOCK_SIZE(16)) bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_direct #(
    .WORD_SIZE(32), .BLOCK_SIZE(16), .NUM_LINES(8), .MEM_LATENCY(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  function automatic logic [31:0] init_val(input int i);
    if (i == 'h25) return 32'hDEAD_BEEF;
    if (i >= 'h40 && i <= 'h4F) return 32'h100 + 32'(i - 'h40);
    return 32'h1000 + 32'(i);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (bus.mem_write_enable) begin
      for (int i = 0; i < 16; i++)
        mem[{bus.mem_ptr[7:4], i[3:0]}] <= bus.mem_wblock[(15-i)*32 +: 32];
      we_count <= we_count + 1;
      we_addr  <= bus.mem_ptr;
    end
  end

  always_comb begin
    bus.mem_rblock = '0;
    for (int i = 0; i < 16; i++)
      bus.mem_rblock[(15-i)*32 +: 32] = mem[{bus.mem_ptr[7:4], i[3:0]}];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issues one request at posedge+1 and holds it until the DUT stops stalling.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input int exp_stalls, input string tag);
    int   stalls = 0;
    logic done = 1'b0;
    bus.cpu_ptr   = addr;
    bus.cpu_wdata = wd;
    bus.cpu_read  = rd;
    bus.cpu_write = wr;
    if (rd) exp_q.push_back(exp_rd);
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (bus.cpu_stall) begin
        stalls++;
        last_mptr = bus.mem_ptr;
      end else begin
        done = 1'b1;
        if (rd) check({tag, " rdata"}, bus.cpu_rdata, exp_q.pop_front());
      end
    end
    check({tag, " completed"}, 32'(done), 32'd1);
    check({tag, " stalls"}, 32'(stalls), 32'(exp_stalls));
    $display("txn %s rd=%0b wr=%0b addr=%h stalls=%0d rdata=%h", tag, rd, wr, addr,
             stalls, bus.cpu_rdata);
    @(posedge clk);
    #1;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
  endtask

  initial begin
    int we0;
    bus.cpu_ptr   = 32'h25;
    bus.cpu_wdata = '0;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset stall", 32'(bus.cpu_stall), 32'd0);
    check("reset mem_we", 32'(bus.mem_write_enable), 32'd0);
    check("reset rdata", bus.cpu_rdata, 32'd0);
    check("reset mem_ptr", bus.mem_ptr, 32'h20);
    mem_init = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;

    access(1'b1, 1'b0, 32'h25, '0, 32'hDEAD_BEEF, 5, "cold_read");
    check("cold mem_ptr", last_mptr, 32'h20);
    check("cold no_wb", 32'(we_count), 32'd0);

    access(1'b0, 1'b1, 32'h21, 32'h1234_5678, '0, 0, "write_hit");
    access(1'b1, 1'b0, 32'h21, '0, 32'h1234_5678, 0, "read_back");
    check("mem 0x21 untouched", mem['h21], 32'h1021);

    access(1'b1, 1'b0, 32'hA1, '0, 32'h10A1, 9, "dirty_evict");
    check("evict we pulses", 32'(we_count), 32'd1);
    check("evict wb ptr", we_addr, 32'h20);
    check("evict mem 0x21", mem['h21], 32'h1234_5678);
    check("evict refill ptr", last_mptr, 32'hA0);
`ifdef DCACHE_STATS_EN
    check("stats miss_count", miss_count, 32'd2);
    check("stats hit_count", hit_count, 32'd2);
`endif

    access(1'b1, 1'b0, 32'h40, '0, 32'h100, 5, "pack_first");
    access(1'b1, 1'b0, 32'h4F, '0, 32'h10F, 0, "pack_last");

    // Dirty line 4, then abort its eviction with reset on the write-strobe cycle.
    access(1'b0, 1'b1, 32'h45, 32'h0000_CAFE, '0, 0, "dirty_45");
    we0 = we_count;
    bus.cpu_ptr  = 32'hC5;
    bus.cpu_read = 1'b1;
    @(negedge clk);
    check("abort miss stall", 32'(bus.cpu_stall), 32'd1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort wb strobe", 32'(bus.mem_write_enable), 32'd1);
    check("abort wb ptr", bus.mem_ptr, 32'h40);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort reset mem_we", 32'(bus.mem_write_enable), 32'd0);
    check("abort reset stall", 32'(bus.cpu_stall), 32'd0);
    $display("txn reset_mid_writeback we=%0b stall=%0b", bus.mem_write_enable, bus.cpu_stall);
    bus.cpu_read = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort no write", 32'(we_count), 32'(we0));
    check("abort mem 0x45", mem['h45], 32'h105);
    access(1'b1, 1'b0, 32'h45, '0, 32'h105, 5, "after_reset");
    check("after_reset no_wb", 32'(we_count), 32'(we0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
